// File: rtl/chip8_sprite_draw.sv
// CHIP-8 DXYN sprite engine: fetches N sprite rows and XORs them into the framebuffer pixel by pixel.
// Define CHIP8_SPRITE_CLIP_EN to suppress off-screen pixels instead of wrapping them.
module chip8_sprite_draw (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  vx,
    input  logic [7:0]  vy,
    input  logic [3:0]  n,
    input  logic [11:0] i_addr,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_readdata,
    output logic [5:0]  fb_x,
    output logic [4:0]  fb_y,
    input  logic        fb_readdata,
    output logic        fb_we,
    output logic        fb_writedata,
    output logic        busy,
    output logic        done,
    output logic        collision
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_LATCH  = 3'd2;
    localparam logic [2:0] S_PIX_RD = 3'd3;
    localparam logic [2:0] S_PIX_WR = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]  state;
    logic [5:0]  x0;
    logic [4:0]  y0;
    logic [3:0]  n_q;
    logic [11:0] base;
    logic [7:0]  sprite;
    logic [3:0]  row;
    logic [2:0]  bit_idx;
    logic [5:0]  pix_x;
    logic [4:0]  pix_y;
    logic        suppressed;
    logic        draw;
    logic        last_bit;
    logic        last_row;

`ifdef CHIP8_SPRITE_CLIP_EN
    logic [6:0] px_full;
    logic [6:0] py_full;
    assign px_full    = {1'b0, x0} + {4'b0, bit_idx};
    assign py_full    = {2'b0, y0} + {3'b0, row};
    assign pix_x      = px_full[5:0];
    assign pix_y      = py_full[4:0];
    assign suppressed = px_full[6] | (py_full[6:5] != 2'b00);
`else
    assign pix_x      = x0 + {3'b0, bit_idx};
    assign pix_y      = y0 + {1'b0, row};
    assign suppressed = 1'b0;
`endif

    assign draw     = sprite[3'd7 - bit_idx] & ~suppressed;
    assign last_bit = (bit_idx == 3'd7);
    assign last_row = (row == (n_q - 4'd1));

    // Operand registers carry no reset; they are only consumed after an accepted start.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            x0   <= 6'(vx % 8'd64);
            y0   <= 5'(vy % 8'd32);
            n_q  <= n;
            base <= i_addr;
        end
        if (state == S_LATCH)
            sprite <= mem_readdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            row       <= 4'd0;
            bit_idx   <= 3'd0;
            collision <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        collision <= 1'b0;
                        row       <= 4'd0;
                        state     <= (n == 4'd0) ? S_DONE : S_FETCH;
                    end
                end
                S_FETCH: state <= S_LATCH;
                S_LATCH: begin
                    bit_idx <= 3'd0;
                    state   <= S_PIX_RD;
                end
                S_PIX_RD, S_PIX_WR: begin
                    if (state == S_PIX_WR && fb_readdata)
                        collision <= 1'b1;
                    if (state == S_PIX_RD && draw) begin
                        state <= S_PIX_WR;
                    end else if (!last_bit) begin
                        bit_idx <= bit_idx + 3'd1;
                        state   <= S_PIX_RD;
                    end else if (!last_row) begin
                        row   <= row + 4'd1;
                        state <= S_FETCH;
                    end else begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr     = 12'd0;
        fb_x         = 6'd0;
        fb_y         = 5'd0;
        fb_we        = 1'b0;
        fb_writedata = 1'b0;
        busy         = (state == S_FETCH) || (state == S_LATCH) ||
                       (state == S_PIX_RD) || (state == S_PIX_WR);
        done         = (state == S_DONE);
        case (state)
            S_FETCH: mem_addr = base + {8'd0, row};
            S_PIX_RD: begin
                if (draw) begin
                    fb_x = pix_x;
                    fb_y = pix_y;
                end
            end
            S_PIX_WR: begin
                fb_x         = pix_x;
                fb_y         = pix_y;
                fb_we        = 1'b1;
                fb_writedata = ~fb_readdata;
            end
            default: ;
        endcase
    end
endmodule
